imem_dmem_arbiter: RTL

- Shares one single-port memory/cache port between the instruction-fetch requester (port I) and the load/store requester (port D).
- One outstanding transaction at a time.
- Request/grant/response handshake on each side; req/ack handshake downstream.
- Includes a watchdog that terminates hung transactions with an error response.
- Sits between the fetch stage, the memory-access stage and the shared cache, so both stages can run against a single memory macro.

---
 rtl/imem_dmem_arbiter_if.sv | 47 ++++
 rtl/imem_dmem_arbiter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/imem_dmem_arbiter_if.sv
// Shared-memory arbiter bus: fetch port, load/store port and downstream port.
// slave = arbiter view, master = requesters/memory view.
interface imem_dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req_i;
  logic [ADDR_W-1:0] i_addr_i;
  logic              i_gnt_o;
  logic              i_rvalid_o;
  logic [DATA_W-1:0] i_rdata_o;
  logic              i_err_o;

  logic              d_req_i;
  logic              d_we_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_wdata_i;
  logic              d_gnt_o;
  logic              d_rvalid_o;
  logic [DATA_W-1:0] d_rdata_o;
  logic              d_err_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  i_req_i, i_addr_i,
    input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
    input  mem_ack_i, mem_rdata_i,
    output i_gnt_o, i_rvalid_o, i_rdata_o, i_err_o,
    output d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output i_req_i, i_addr_i,
    output d_req_i, d_we_i, d_addr_i, d_wdata_i,
    output mem_ack_i, mem_rdata_i,
    input  i_gnt_o, i_rvalid_o, i_rdata_o, i_err_o,
    input  d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Fetch / load-store arbiter onto one memory port, one transaction in flight.
// ARB_RR_EN selects round-robin ties; default is fixed D-over-I priority.
module imem_dmem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input logic clk_i,
  input logic rst_i,
  imem_dmem_arbiter_if.slave bus
);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit WD_EN = (TIMEOUT > 0);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state;
  logic              owner_d;
  logic [CNT_W-1:0]  cnt;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;
  logic              i_err;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;

  logic              idle;
  logic              gnt_i;
  logic              gnt_d;
  logic              expire;
  logic              done;
  logic [DATA_W-1:0] rsp_data;

  assign idle = (state == IDLE);

`ifdef ARB_RR_EN
  logic last_d;

  // On a tie the port that did not win last time is served.
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (idle) begin
      if (bus.i_req_i && bus.d_req_i) begin
        gnt_i = last_d;
        gnt_d = ~last_d;
      end else begin
        gnt_i = bus.i_req_i;
        gnt_d = bus.d_req_i;
      end
    end
  end
`else
  // D first so a stalled memory stage never waits behind fetch.
  assign gnt_d = idle & bus.d_req_i;
  assign gnt_i = idle & bus.i_req_i & ~bus.d_req_i;
`endif

  assign expire = WD_EN && !bus.mem_ack_i && (cnt == CNT_LAST);
  assign done   = bus.mem_ack_i | expire;

  assign rsp_data = (expire || mem_we) ? '0 : bus.mem_rdata_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      owner_d   <= 1'b0;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rvalid  <= 1'b0;
      i_rdata   <= '0;
      i_err     <= 1'b0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
`ifdef ARB_RR_EN
      last_d    <= 1'b1;
`endif
    end else begin
      i_rvalid <= 1'b0;
      i_err    <= 1'b0;
      d_rvalid <= 1'b0;
      d_err    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gnt_i || gnt_d) begin
            state     <= BUSY;
            owner_d   <= gnt_d;
            cnt       <= '0;
            mem_req   <= 1'b1;
            mem_we    <= gnt_d & bus.d_we_i;
            mem_addr  <= gnt_d ? bus.d_addr_i : bus.i_addr_i;
            mem_wdata <= gnt_d ? bus.d_wdata_i : '0;
`ifdef ARB_RR_EN
            last_d    <= gnt_d;
`endif
          end
        end
        BUSY: begin
          if (done) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            if (owner_d) begin
              d_rvalid <= 1'b1;
              d_err    <= expire;
              d_rdata  <= rsp_data;
            end else begin
              i_rvalid <= 1'b1;
              i_err    <= expire;
              i_rdata  <= rsp_data;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.i_gnt_o     = gnt_i;
  assign bus.d_gnt_o     = gnt_d;
  assign bus.mem_req_o   = mem_req;
  assign bus.mem_we_o    = mem_we;
  assign bus.mem_addr_o  = mem_addr;
  assign bus.mem_wdata_o = mem_wdata;
  assign bus.i_rvalid_o  = i_rvalid;
  assign bus.i_rdata_o   = i_rdata;
  assign bus.i_err_o     = i_err;
  assign bus.d_rvalid_o  = d_rvalid;
  assign bus.d_rdata_o   = d_rdata;
  assign bus.d_err_o     = d_err;
endmodule
